sha256_host_mem: RTL
====================

# sha256_host_mem

Host-side companion for the SHA-256 engine: owns the word-addressed memory the engine reads its message from and writes its hash to. It accepts message words from a host valid/ready stream and stores them at MSG_BASE. It then pulses the engine's start, answers engine memory requests with fixed 1-cycle read latency, and streams the 8 hash words back out on a valid/ready stream. It sits between the host/testbench fabric and the engine's mem_* and start/done pins.

## Interface
- NUM_OF_WORDS, 20, message length in 32-bit words (1..DEPTH-8-MSG_BASE)
- DEPTH, 64, memory depth in words
- MSG_BASE, 0, word address of message; driven on eng_message_addr
- OUT_BASE, 32, word address of hash; driven on eng_output_addr

Ports:
- clk  in  1  clock; memory and FSM clock (engine mem_clk is the same clock)
- reset_n  in  1  reset, asynchronous, active-low
- in_valid / in_ready  in / out  1  host message word handshake
- in_data  in  32  message word
- out_valid / out_ready  out / in  1  hash word handshake
- out_data  out  32  hash word, h0 first
- busy  out  1  high in every state except LOAD
- err  out  1  sticky: illegal engine access seen
- eng_start  out  1  one-cycle start pulse to engine
- eng_message_addr, eng_output_addr  out  16  constants MSG_BASE, OUT_BASE
- eng_done  in  1  engine done; high while engine idle
- eng_mem_we  in  1  engine write enable
- eng_mem_addr  in  16  engine word address
- eng_mem_write_data  in  32  engine write data
- eng_mem_read_data  out  32  read data for engine

## Operation
- Storage: DEPTH x 32 array, not reset. Engine port and drain read port operate independently.
- FSM states: LOAD, START, WAIT_BUSY, WAIT_DONE, DRAIN.
- LOAD: in_ready=1. Each in_valid&&in_ready writes mem[MSG_BASE+cnt]; cnt++. Accepting word NUM_OF_WORDS-1 -> START, cnt cleared.
- START: eng_start=1 for exactly this one cycle -> WAIT_BUSY.
- WAIT_BUSY: wait for eng_done==0, -> WAIT_DONE. Engine done is high before start, so a done high here is stale and is ignored.
- WAIT_DONE: wait for eng_done==1 -> DRAIN, rd_idx=0.
- DRAIN: when !out_valid || out_ready, and rd_idx<8: out_data<=mem[OUT_BASE+rd_idx], out_valid<=1, rd_idx++. When !out_valid || out_ready and rd_idx==8: out_valid<=0 -> LOAD.
- Engine reads, every cycle in every state: eng_mem_read_data <= (eng_mem_addr<DEPTH) ? mem[eng_mem_addr] : 0.
- Engine writes: mem[eng_mem_addr] <= eng_mem_write_data when eng_mem_we, addr<DEPTH, and state is WAIT_BUSY or WAIT_DONE.
  - eng_mem_we with addr>=DEPTH, or in any other state: write dropped, err<=1.
- Read of an address written in the same cycle returns the old data (read-before-write).

## Timing
- Reset values:
  - state=LOAD, cnt=0, rd_idx=0
  - in_ready=0 during reset; in_ready rises with LOAD on the first clock after release
  - out_valid=0, out_data=0, eng_start=0, eng_mem_read_data=0, busy=0, err=0
- Engine read latency: exactly 1 cycle; address at edge n gives data valid after edge n+1.
- Load throughput: 1 word/cycle. Last accepted word at edge n gives: START during cycle n+1, eng_start high for one cycle, in_ready low from cycle n+1.
- Drain throughput: 1 word/cycle with out_ready held high. out_valid first rises on the edge after DRAIN is entered.
- out_data/out_valid are held stable while out_valid && !out_ready.
- After the 8th word is accepted, LOAD and in_ready=1 follow on the next edge. Blocks run back-to-back with no idle state.
- err clears only on reset.
- Reset asserted mid-operation: immediate return to reset values. Memory contents are undefined-preserved. A partial load restarts at cnt=0.

## Test plan
- Reset: assert reset_n=0 mid-LOAD after 5 words -> all outputs at reset values; the next 20 words land at mem[0..19], checked via engine reads of addresses 0..19.
- Load + start: stream 0x00000001..0x00000014 continuously -> in_ready drops after the 20th word; exactly one eng_start pulse; busy=1.
- Read latency: behavioural engine drives addr 0..19 back-to-back -> eng_mem_read_data equals the word written for addr k one cycle after addr k is presented.
- Stale done: eng_done held 1 for 3 cycles after start, then 0 for 10, then 1 -> DRAIN entered only after the final rise.
- Write-back + drain: engine writes 0xA0000000..0xA0000007 to 32..39, then done. With out_ready=1 -> 8 consecutive beats in order. With out_ready toggling 1,0,0,1 -> each beat held stable with no loss or duplication.
- Illegal access: eng_mem_we with addr 70, and eng_mem_we during LOAD -> memory unchanged, err=1 and sticky; a read of addr 70 returns 0.

Source files
------------

// File: rtl/sha256_host_mem.sv
// Host-side memory for the SHA-256 engine: loads the message from a host stream, starts the
// engine, serves its 1-cycle-latency memory port and streams the 8 hash words back out.
module sha256_host_mem #(
    parameter int unsigned NUM_OF_WORDS = 20,
    parameter int unsigned DEPTH        = 64,
    parameter int unsigned MSG_BASE     = 0,
    parameter int unsigned OUT_BASE     = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy,
    output logic        err,
    output logic        eng_start,
    output logic [15:0] eng_message_addr,
    output logic [15:0] eng_output_addr,
    input  logic        eng_done,
    input  logic        eng_mem_we,
    input  logic [15:0] eng_mem_addr,
    input  logic [31:0] eng_mem_write_data,
    output logic [31:0] eng_mem_read_data
);
    localparam int unsigned   AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] MSG_A    = AW'(MSG_BASE);
    localparam logic [AW-1:0] OUT_A    = AW'(OUT_BASE);
    localparam logic [AW-1:0] LAST_CNT = AW'(NUM_OF_WORDS - 1);

    typedef enum logic [2:0] {LOAD, START, WAIT_BUSY, WAIT_DONE, DRAIN} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [3:0]    rd_idx_q, rd_idx_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic [31:0]   out_data_q, out_data_d;
    logic          err_q, err_d;
    logic [31:0]   rdata_q;
    logic [31:0]   mem [DEPTH];

    logic          host_we;
    logic          eng_in_range;
    logic          eng_we_ok;
    logic [AW-1:0] eng_a;

    always_comb begin
        eng_a        = eng_mem_addr[AW-1:0];
        eng_in_range = 32'(eng_mem_addr) < DEPTH;
        eng_we_ok    = eng_mem_we && eng_in_range &&
                       (state_q == WAIT_BUSY || state_q == WAIT_DONE);
        host_we      = (state_q == LOAD) && in_valid && in_ready_q;

        state_d     = state_q;
        cnt_d       = cnt_q;
        rd_idx_d    = rd_idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        err_d       = err_q | (eng_mem_we && !eng_we_ok);

        case (state_q)
            LOAD: begin
                if (host_we) begin
                    if (cnt_q == LAST_CNT) begin
                        state_d = START;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            START:     state_d = WAIT_BUSY;
            // done is still high from the previous idle period until the engine picks up start
            WAIT_BUSY: if (!eng_done) state_d = WAIT_DONE;
            WAIT_DONE: begin
                if (eng_done) begin
                    state_d  = DRAIN;
                    rd_idx_d = '0;
                end
            end
            DRAIN: begin
                if (!out_valid_q || out_ready) begin
                    if (rd_idx_q < 4'd8) begin
                        out_data_d  = mem[OUT_A + AW'(rd_idx_q)];
                        out_valid_d = 1'b1;
                        rd_idx_d    = rd_idx_q + 1'b1;
                    end else begin
                        out_valid_d = 1'b0;
                        rd_idx_d    = '0;
                        state_d     = LOAD;
                    end
                end
            end
            default: state_d = LOAD;
        endcase

        // registered so that in_ready stays low while reset is held
        in_ready_d = (state_d == LOAD);
    end

    always_ff @(posedge clk) begin
        if (host_we)   mem[MSG_A + cnt_q] <= in_data;
        if (eng_we_ok) mem[eng_a]         <= eng_mem_write_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= LOAD;
            cnt_q       <= '0;
            rd_idx_q    <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_idx_q    <= rd_idx_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            err_q       <= err_d;
            rdata_q     <= eng_in_range ? mem[eng_a] : '0;
        end
    end

    assign in_ready          = in_ready_q;
    assign out_valid         = out_valid_q;
    assign out_data          = out_data_q;
    assign busy              = (state_q != LOAD);
    assign err               = err_q;
    assign eng_start         = (state_q == START);
    assign eng_message_addr  = 16'(MSG_BASE);
    assign eng_output_addr   = 16'(OUT_BASE);
    assign eng_mem_read_data = rdata_q;

endmodule
